// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op and state encodings, iteration count, magnitude helper.
package md_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  function automatic logic [31:0] md_abs(
    input logic [31:0] x,
    input logic        neg
  );
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/busy/done handshake and HI/LO access bundle
// between the execute-stage control and the mul/div unit.
interface mul_div_unit_if;
  import md_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, input1, input2,
    output wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, input1, input2,
    input  wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_sign_fix.sv
// Sign correction of the raw magnitude result into HI/LO values,
// including the divide-by-zero override.
module md_sign_fix
  import md_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [63:0] i_acc,
  input  logic        i_neg_q,
  input  logic        i_neg_r,
  input  logic        i_dz,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_mul;

  always_comb begin
    w_mul  = ~i_op[1];
    w_prod = i_neg_q ? -i_acc : i_acc;
    w_q    = i_neg_q ? -i_acc[31:0] : i_acc[31:0];
    w_r    = i_neg_r ? -i_acc[63:32] : i_acc[63:32];
    o_hi   = w_r;
    o_lo   = w_q;
    unique case (1'b1)
      w_mul: begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
      end
      // remainder already restores the dividend when the divisor is zero
      i_dz:    o_lo = '1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  md_op_e      r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic [32:0] w_diff;
  logic [63:0] w_mul_nx;
  logic [63:0] w_div_nx;
  logic [63:0] w_acc_nx;
  logic [31:0] w_hi_fix;
  logic [31:0] w_lo_fix;

  always_comb begin
    w_a_neg  = ~bus.op[0] & bus.input1[31];
    w_b_neg  = ~bus.op[0] & bus.input2[31];
    w_mag_a  = md_abs(bus.input1, w_a_neg);
    w_mag_b  = md_abs(bus.input2, w_b_neg);
    w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    w_shl    = {r_acc[63:32], r_acc[31]};
    w_diff   = w_shl - {1'b0, r_opnd};
    w_mul_nx = r_acc[0] ? {w_sum, r_acc[31:1]}
                        : {1'b0, r_acc[63:1]};
    w_div_nx = w_diff[32] ? {w_shl[31:0], r_acc[30:0], 1'b0}
                          : {w_diff[31:0], r_acc[30:0], 1'b1};
    w_acc_nx = r_op[1] ? w_div_nx : w_mul_nx;
  end

  md_sign_fix u_fix (
    .i_op    (r_op),
    .i_acc   (r_acc),
    .i_neg_q (r_neg_q),
    .i_neg_r (r_neg_r),
    .i_dz    (r_dz),
    .o_hi    (w_hi_fix),
    .o_lo    (w_lo_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_op    <= MD_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(ITER - 1);
            r_op    <= bus.op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= bus.op[1] & (bus.input2 == '0);
            // mult: {0, multiplier} + multiplicand; div: {rem=0, dividend}
            r_acc   <= bus.op[1] ? {32'b0, w_mag_a} : {32'b0, w_mag_b};
            r_opnd  <= bus.op[1] ? w_mag_b : w_mag_a;
          end else begin
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
